// File: rtl/sbox_subbytes_seq.sv
// Multi-byte AES SubBytes / InvSubBytes engine. A block of NBYTES bytes is
// latched on accept. BPC lookup lanes then rewrite it BPC bytes per cycle,
// in place, and the result is handed out over a valid/ready handshake.
module sbox_subbytes_seq #(
  parameter int NBYTES = 16,
  parameter int BPC    = 4
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_mode,
  input  logic [8*NBYTES-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES-1:0]   out_data
);

  localparam int NCHUNK = NBYTES / BPC;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if (BPC < 1 || BPC > NBYTES || (NBYTES % BPC) != 0) begin : g_bad_bpc
    $error("sbox_subbytes_seq: BPC must divide NBYTES and lie in 1..NBYTES");
  end

  // FIPS-197 tables, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  localparam logic [2047:0] SBOX_INV = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q,   cnt_d;
  logic                 mode_q,  mode_d;
  logic [8*NBYTES-1:0]  work_q,  work_d;
  logic [7:0]           lane_in  [BPC];
  logic [7:0]           lane_out [BPC];

  function automatic logic [7:0] sub_byte(input logic [7:0] b, input logic inv);
    int idx;
    idx = 2047 - 8 * int'(b);
    return inv ? SBOX_INV[idx -: 8] : SBOX_FWD[idx -: 8];
  endfunction

  // Each lane looks up its byte of the current chunk.
  for (genvar j = 0; j < BPC; j++) begin : g_lane
    assign lane_in[j]  = work_q[8*NBYTES-1 - 8*(int'(cnt_q)*BPC + j) -: 8];
    assign lane_out[j] = sub_byte(lane_in[j], mode_q);
  end

  // Next-state logic: accept in IDLE, write one chunk per BUSY cycle, hold in DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    work_d  = work_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = in_data;
          mode_d  = in_mode;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        for (int j = 0; j < BPC; j++) begin
          work_d[8*NBYTES-1 - 8*(int'(cnt_q)*BPC + j) -: 8] = lane_out[j];
        end
        if (cnt_q == CNT_W'(NCHUNK-1)) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset also clears the work register so aborted blocks leave nothing behind.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      work_q  <= work_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = work_q;

endmodule

// File: tb/tb_sbox_subbytes_seq.sv
// Bench for sbox_subbytes_seq: five 16-byte instances (BPC 1,2,4,8,16) and
// one 4-byte BPC=1 instance, checked against directed vectors and a
// GF(2^8)-derived reference S-box.
module tb_sbox_subbytes_seq;

  logic CLK = 1'b0;
  logic RST_N;
  always #5 CLK = ~CLK;

  logic         in_valid_s  [6];
  logic         in_mode_s   [6];
  logic         out_ready_s [6];
  logic [127:0] in_data_s   [6];
  wire          in_ready_s  [6];
  wire          out_valid_s [6];
  wire  [127:0] out_data_s  [6];

  for (genvar k = 0; k < 6; k++) begin : g_dut
    if (k < 5) begin : g_w
      sbox_subbytes_seq #(.NBYTES(16), .BPC(1 << k)) u_dut (
        .CLK(CLK), .RST_N(RST_N),
        .in_valid(in_valid_s[k]), .in_ready(in_ready_s[k]),
        .in_mode(in_mode_s[k]), .in_data(in_data_s[k]),
        .out_valid(out_valid_s[k]), .out_ready(out_ready_s[k]),
        .out_data(out_data_s[k])
      );
    end else begin : g_n
      sbox_subbytes_seq #(.NBYTES(4), .BPC(1)) u_dut (
        .CLK(CLK), .RST_N(RST_N),
        .in_valid(in_valid_s[k]), .in_ready(in_ready_s[k]),
        .in_mode(in_mode_s[k]), .in_data(in_data_s[k][31:0]),
        .out_valid(out_valid_s[k]), .out_ready(out_ready_s[k]),
        .out_data(out_data_s[k][31:0])
      );
      assign out_data_s[k][127:32] = '0;
    end
  end

  int errors   = 0;
  int n_checks = 0;

  logic [7:0] fwd_tab [256];
  logic [7:0] inv_tab [256];

  typedef struct {
    int           k;
    logic         mode;
    logic [127:0] din;
    logic [127:0] dexp;
    int           lat;
    string        name;
  } vec_t;

  vec_t vecs [6];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    logic [7:0] e;
    r = 8'h01;
    p = a;
    e = 8'd254;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gmul(r, p);
      p = gmul(p, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] t;
    t = {x, x} << n;
    return t[15:8];
  endfunction

  function automatic logic [127:0] model(input logic mode, input logic [127:0] d, input int nb);
    logic [127:0] r;
    logic [7:0]   b;
    r = '0;
    for (int i = 0; i < nb; i++) begin
      b = d[8*nb-1-8*i -: 8];
      r[8*nb-1-8*i -: 8] = mode ? inv_tab[b] : fwd_tab[b];
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called #1 after an edge with the DUT idle; returns #1 after the accept edge.
  task automatic start_block(input int k, input logic mode, input logic [127:0] d);
    in_data_s[k]  = d;
    in_mode_s[k]  = mode;
    in_valid_s[k] = 1'b1;
    @(posedge CLK); #1;
    in_valid_s[k] = 1'b0;
    in_data_s[k]  = {$urandom(), $urandom(), $urandom(), $urandom()};
    in_mode_s[k]  = ~mode;
  endtask

  task automatic wait_done(input int k, output int lat);
    lat = 0;
    while (!out_valid_s[k] && lat < 64) begin
      @(posedge CLK); #1;
      lat++;
    end
    if (!out_valid_s[k]) begin
      n_checks++;
      errors++;
      $display("FAIL timeout: out_valid never rose on instance %0d", k);
    end
  endtask

  task automatic release_block(input int k);
    out_ready_s[k] = 1'b1;
    @(posedge CLK); #1;
    out_ready_s[k] = 1'b0;
  endtask

  task automatic run_block(input int k, input logic mode, input logic [127:0] d,
                           input logic [127:0] exp, input int explat, input string name,
                           output logic [127:0] res);
    int lat;
    start_block(k, mode, d);
    wait_done(k, lat);
    res = out_data_s[k];
    chk({name, "_data"}, res, exp);
    chk({name, "_latency"}, 128'(lat), 128'(explat));
    release_block(k);
    chk({name, "_vld_drop"}, 128'(out_valid_s[k]), 128'(0));
  endtask

  initial begin
    logic [127:0] res;
    logic [127:0] d;
    logic [127:0] e;
    logic         m;
    int           lat;

    for (int i = 0; i < 256; i++) begin
      logic [7:0] v;
      logic [7:0] s;
      v = ginv(8'(i));
      s = v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
      fwd_tab[i] = s;
      inv_tab[s] = 8'(i);
    end

    vecs[0] = '{2, 1'b0, 128'h193de3bea0f4e22b9ac68d2ae9f84808, 128'hd42711aee0bf98f1b8b45de51e415230, 4, "fips_fwd"};
    vecs[1] = '{2, 1'b1, 128'hd42711aee0bf98f1b8b45de51e415230, 128'h193de3bea0f4e22b9ac68d2ae9f84808, 4, "fips_inv"};
    vecs[2] = '{5, 1'b0, 128'h0001ff53, 128'h637c16ed, 4, "corner_fwd"};
    vecs[3] = '{5, 1'b1, 128'h637c16ed, 128'h0001ff53, 4, "corner_inv"};
    vecs[4] = '{4, 1'b0, 128'h193de3bea0f4e22b9ac68d2ae9f84808, 128'hd42711aee0bf98f1b8b45de51e415230, 1, "bpc16_fwd"};
    vecs[5] = '{0, 1'b1, 128'hd42711aee0bf98f1b8b45de51e415230, 128'h193de3bea0f4e22b9ac68d2ae9f84808, 16, "bpc1_inv"};

    for (int k = 0; k < 6; k++) begin
      in_valid_s[k]  = 1'b0;
      in_mode_s[k]   = 1'b0;
      out_ready_s[k] = 1'b0;
      in_data_s[k]   = '0;
    end

    // Reset state.
    RST_N = 1'b1;
    #1 RST_N = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_out_valid", 128'(out_valid_s[2]), 128'(0));
    chk("rst_in_ready",  128'(in_ready_s[2]),  128'(1));
    chk("rst_out_data",  out_data_s[2], 128'h0);
    chk("rst_out_data_n", out_data_s[5], 128'h0);
    RST_N = 1'b1;
    @(posedge CLK); #1;
    chk("idle_in_ready", 128'(in_ready_s[2]), 128'(1));

    // Directed vectors.
    for (int v = 0; v < 6; v++) begin
      run_block(vecs[v].k, vecs[v].mode, vecs[v].din, vecs[v].dexp, vecs[v].lat, vecs[v].name, res);
      chk({vecs[v].name, "_rdy_back"}, 128'(in_ready_s[vecs[v].k]), 128'(1));
    end

    // Backpressure: DONE holds, in_valid ignored, result kept after release.
    d = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    e = 128'hd42711aee0bf98f1b8b45de51e415230;
    start_block(2, 1'b0, d);
    wait_done(2, lat);
    for (int c = 0; c < 10; c++) begin
      chk("bp_out_valid", 128'(out_valid_s[2]), 128'(1));
      chk("bp_out_data",  out_data_s[2], e);
      chk("bp_in_ready",  128'(in_ready_s[2]), 128'(0));
      if (c == 3) begin
        in_data_s[2]  = 128'h00112233445566778899aabbccddeeff;
        in_mode_s[2]  = 1'b1;
        in_valid_s[2] = 1'b1;
      end else begin
        in_valid_s[2] = 1'b0;
      end
      @(posedge CLK); #1;
    end
    in_valid_s[2] = 1'b0;
    release_block(2);
    chk("bp_rel_out_valid", 128'(out_valid_s[2]), 128'(0));
    chk("bp_rel_in_ready",  128'(in_ready_s[2]),  128'(1));
    chk("bp_rel_kept_data", out_data_s[2], e);

    // Reset during the second BUSY cycle aborts the block.
    start_block(2, 1'b0, d);
    @(posedge CLK); #1;
    RST_N = 1'b0;
    #1;
    chk("midrst_out_valid", 128'(out_valid_s[2]), 128'(0));
    chk("midrst_in_ready",  128'(in_ready_s[2]),  128'(1));
    chk("midrst_out_data",  out_data_s[2], 128'h0);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    @(posedge CLK); #1;
    run_block(2, 1'b0, d, e, 4, "after_rst", res);

    // Sweep: random blocks, random mode, then the opposite mode back.
    for (int k = 0; k < 5; k++) begin
      for (int n = 0; n < 200; n++) begin
        d = {$urandom(), $urandom(), $urandom(), $urandom()};
        m = 1'($urandom_range(0, 1));
        e = model(m, d, 16);
        run_block(k, m, d, e, 16 >> k, "sweep_pass1", res);
        run_block(k, ~m, res, d, 16 >> k, "sweep_roundtrip", res);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, n_checks);
    $finish;
  end

endmodule
